smart_cargo_insert_planner: RTL
===============================

# smart_cargo_insert_planner

Insertion planner that sits directly upstream of the 16-entry SmartCargo request-queue RAM. It accepts one transport request at a time (tipo, origem, destino) and turns it into two queue entries: a pickup stop (origem=destino=origem) and a delivery stop (origem, destino). For each entry it scans the queue through the RAM's secondary read ports, finds the first position that lies on the path between consecutive stops, and drives `fit` at that index. If no position fits, it drives `weT` to append. It also tracks queue occupancy and refuses requests that do not fit in the remaining capacity.

## Interface
- No parameters; depth fixed at 16, floor width fixed at 2 bits.
- `clk` in 1: sole clock, rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `novo_pedido` in 1: one-cycle request strobe; sampled only in IDLE.
- `in_tipo_objeto`, `in_origem_objeto`, `in_destino_objeto` in 2 each: request fields, latched on accept.
- `andar_atual` in 2: current floor of the cargo car; used as the "previous stop" for index 0.
- `shift` in 1: same strobe that pops the RAM head.
- `saidaSecundaria`, `saidaSecundariaAnterior` in 2 each: RAM reads at `addrSecundario` and `addrSecundarioAnterior` (destination floor field).
- `addrSecundario`, `addrSecundarioAnterior` out 4: scan index k and k-1 (k-1 is 0 when k=0).
- `out_tipo_objeto`, `out_origem_objeto`, `out_destino_objeto` out 2: data presented to the RAM write inputs.
- `fit`, `weT` out 1: RAM insert and append strobes.
- `ocupado` out 1: high in every state except IDLE.
- `pronto` out 1: one-cycle pulse when both entries are written.
- `recusado` out 1: one-cycle pulse when a request is rejected.
- `ocupacao` out 5: entry count, 0–16.

## Operation
- States:
  - IDLE
  - SCAN_P (pickup scan)
  - WRITE_P
  - SCAN_D (delivery scan)
  - WRITE_D
  - DONE
- IDLE: when `novo_pedido`=1, latch the fields.
  - If `ocupacao` > 14: pulse `recusado` next cycle and stay in IDLE.
  - Otherwise go to SCAN_P with k=0.
- Target floor T:
  - Pickup: T = origem; out fields = {tipo, origem, origem}.
  - Delivery: T = destino; out fields = {tipo, origem, destino}.
- Scan (one index per cycle):
  - prev = `andar_atual` if k=0, else `saidaSecundariaAnterior`; next = `saidaSecundaria`.
  - Fit when (prev ≤ T ≤ next) or (prev ≥ T ≥ next).
  - If k == `ocupacao`: go to WRITE with append mode.
  - Else if fit: go to WRITE with insert at k.
  - Else: k+1.
- WRITE_P / WRITE_D: assert `fit` (insert mode, `addrSecundario`=k) or `weT` (append) for exactly one cycle; `ocupacao`+1.
  - After WRITE_P: record pidx = k (append: pidx = old `ocupacao`), then SCAN_D with k = pidx+1.
- DONE: pulse `pronto`, return to IDLE.
- Occupancy:
  - `shift` with `ocupacao`>0 decrements; `shift` at 0 is ignored.
  - A write and a shift in the same cycle never both take effect (see Timing).
- `shift` during SCAN_P: restart at k=0.
- `shift` during SCAN_D: pidx = max(pidx-1, 0) and restart at k=pidx+1.
- `clear`, from any state: IDLE; `ocupacao`=0; k and pidx = 0; all strobes 0.

## Timing
- Reset values of all outputs: 0.
- `addrSecundario`, `addrSecundarioAnterior`, the out data fields and state are registered.
- The fit compare is combinational on the RAM's asynchronous read outputs in the same cycle.
- `fit` = (WRITE state, insert mode) AND NOT `shift`; `weT` = (WRITE state, append mode) AND NOT `shift`. Both are combinational so a same-cycle `shift` suppresses the write.
- Suppressed write: the FSM returns to the matching SCAN state with the shift adjustment above.
- Latency, no shift, ocupacao=n, pickup at index a, delivery at index b:
  - Accept to `pronto` = 1 + (a+1) + 1 + (b−a) + 1 + 1 cycles.
  - Empty queue: 6 cycles.
- `novo_pedido` while `ocupado`=1 is ignored, with no queueing.

## Configuration
- `SMART_INSERT_EN` defined: path-ordered scan as described.
- Not defined:
  - SCAN states are bypassed; both entries are always appended with `weT`: IDLE → WRITE_P → WRITE_D → DONE.
  - The same shift-suppression rule applies, and capacity check and `recusado` still apply.
  - `addrSecundario` and `addrSecundarioAnterior` stay 0.

## Test plan
- Empty queue, `andar_atual`=0, request o=1,d=3:
  - `weT` pulses in two cycles with data {t,1,1} then {t,1,3}.
  - `ocupacao`=2; `pronto` 6 cycles after accept.
- Queue floors [3] from `andar_atual`=0, request o=1,d=2:
  - Pickup inserted by `fit` at k=0; delivery by `fit` at k=1.
  - Final floors [1,2,3].
- `ocupacao`=15, request → `recusado` pulse; no `fit`/`weT`; `ocupacao` remains 15.
- `shift` asserted in the WRITE_P cycle:
  - `fit` stays low and `ocupacao` decrements.
  - Rescan from k=0, then write; final count = old−1+2.
- `clear` mid SCAN_D → all outputs 0 next cycle; a new request is accepted normally.
- Without `SMART_INSERT_EN`, queue floors [3], request o=1,d=2 → two appends; final floors [3,1,2].

Source files
------------

// File: rtl/smart_cargo_insert_planner.sv
// Turns one transport request into a pickup and a delivery entry for the 16-deep request queue.
// Define SMART_INSERT_EN for the path-ordered scan; otherwise both entries are simply appended.
module smart_cargo_insert_planner (
    input  logic       clk,
    input  logic       clear,
    input  logic       novo_pedido,
    input  logic [1:0] in_tipo_objeto,
    input  logic [1:0] in_origem_objeto,
    input  logic [1:0] in_destino_objeto,
    input  logic [1:0] andar_atual,
    input  logic       shift,
    input  logic [1:0] saidaSecundaria,
    input  logic [1:0] saidaSecundariaAnterior,
    output logic [3:0] addrSecundario,
    output logic [3:0] addrSecundarioAnterior,
    output logic [1:0] out_tipo_objeto,
    output logic [1:0] out_origem_objeto,
    output logic [1:0] out_destino_objeto,
    output logic       fit,
    output logic       weT,
    output logic       ocupado,
    output logic       pronto,
    output logic       recusado,
    output logic [4:0] ocupacao
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN_P  = 3'd1,
        S_WRITE_P = 3'd2,
        S_SCAN_D  = 3'd3,
        S_WRITE_D = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] k_q, k_d, kprev_q, kprev_d, pidx_q, pidx_d;
    logic       append_q, append_d;
    logic [4:0] occ_q, occ_d;
    logic [1:0] tipo_q, tipo_d, orig_q, orig_d, dest_q, dest_d, odest_q, odest_d;
    logic       rec_q, rec_d;
    logic       write_s;

`ifdef SMART_INSERT_EN
    logic [1:0] target_s, prev_s;
    logic       fit_here_s, at_end_s;
    logic [3:0] pidx_dec_s;

    function automatic logic on_path(input logic [1:0] p, input logic [1:0] t, input logic [1:0] n);
        return ((p <= t) && (t <= n)) || ((p >= t) && (t >= n));
    endfunction

    // Path test between the stop before index k and the stop at k
    always_comb begin
        target_s   = (state_q == S_SCAN_D) ? dest_q : orig_q;
        prev_s     = (k_q == 4'd0) ? andar_atual : saidaSecundariaAnterior;
        fit_here_s = on_path(prev_s, target_s, saidaSecundaria);
        at_end_s   = ({1'b0, k_q} == occ_q);
        pidx_dec_s = (pidx_q == 4'd0) ? 4'd0 : pidx_q - 4'd1;
    end
`else
    logic unused_scan_s;
    assign unused_scan_s = ^{andar_atual, saidaSecundaria, saidaSecundariaAnterior, pidx_q};
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= S_IDLE;
            k_q      <= 4'd0;
            kprev_q  <= 4'd0;
            pidx_q   <= 4'd0;
            append_q <= 1'b0;
            occ_q    <= 5'd0;
            tipo_q   <= 2'd0;
            orig_q   <= 2'd0;
            dest_q   <= 2'd0;
            odest_q  <= 2'd0;
            rec_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            kprev_q  <= kprev_d;
            pidx_q   <= pidx_d;
            append_q <= append_d;
            occ_q    <= occ_d;
            tipo_q   <= tipo_d;
            orig_q   <= orig_d;
            dest_q   <= dest_d;
            odest_q  <= odest_d;
            rec_q    <= rec_d;
        end
    end

    // Next-state and scan-index logic
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        pidx_d   = pidx_q;
        append_d = append_q;
        tipo_d   = tipo_q;
        orig_d   = orig_q;
        dest_d   = dest_q;
        odest_d  = odest_q;
        rec_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (novo_pedido) begin
                    if (occ_q > 5'd14) begin
                        rec_d = 1'b1;
                    end else begin
                        tipo_d  = in_tipo_objeto;
                        orig_d  = in_origem_objeto;
                        dest_d  = in_destino_objeto;
                        odest_d = in_origem_objeto;
                        k_d     = 4'd0;
`ifdef SMART_INSERT_EN
                        state_d = S_SCAN_P;
`else
                        append_d = 1'b1;
                        state_d  = S_WRITE_P;
`endif
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef SMART_INSERT_EN
            S_SCAN_P, S_SCAN_D: begin
                if (shift) begin
                    if (state_q == S_SCAN_P) begin
                        k_d = 4'd0;
                    end else begin
                        pidx_d = pidx_dec_s;
                        k_d    = pidx_dec_s + 4'd1;
                    end
                end else if (at_end_s) begin
                    append_d = 1'b1;
                    state_d  = (state_q == S_SCAN_P) ? S_WRITE_P : S_WRITE_D;
                end else if (fit_here_s) begin
                    append_d = 1'b0;
                    state_d  = (state_q == S_SCAN_P) ? S_WRITE_P : S_WRITE_D;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
`endif
            S_WRITE_P: begin
                if (shift) begin
`ifdef SMART_INSERT_EN
                    k_d     = 4'd0;
                    state_d = S_SCAN_P;
`else
                    state_d = S_WRITE_P;
`endif
                end else begin
                    odest_d = dest_q;
`ifdef SMART_INSERT_EN
                    pidx_d  = k_q;
                    k_d     = k_q + 4'd1;
                    state_d = S_SCAN_D;
`else
                    state_d = S_WRITE_D;
`endif
                end
            end
            S_WRITE_D: begin
                if (shift) begin
`ifdef SMART_INSERT_EN
                    pidx_d  = pidx_dec_s;
                    k_d     = pidx_dec_s + 4'd1;
                    state_d = S_SCAN_D;
`else
                    state_d = S_WRITE_D;
`endif
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        kprev_d = (k_d == 4'd0) ? 4'd0 : k_d - 4'd1;
    end

    // Write strobes lose to a same-cycle shift so the RAM never sees both
    always_comb begin
        write_s  = ((state_q == S_WRITE_P) || (state_q == S_WRITE_D)) && !shift;
        fit      = write_s && !append_q;
        weT      = write_s && append_q;
        ocupado  = (state_q != S_IDLE);
        pronto   = (state_q == S_DONE);
    end

    // Occupancy count
    always_comb begin
        if (write_s) begin
            occ_d = occ_q + 5'd1;
        end else if (shift && (occ_q != 5'd0)) begin
            occ_d = occ_q - 5'd1;
        end else begin
            occ_d = occ_q;
        end
    end

    assign addrSecundario         = k_q;
    assign addrSecundarioAnterior = kprev_q;
    assign out_tipo_objeto        = tipo_q;
    assign out_origem_objeto      = orig_q;
    assign out_destino_objeto     = odest_q;
    assign recusado               = rec_q;
    assign ocupacao               = occ_q;

endmodule
